// File: rtl/chart_sequencer.sv
// chart_sequencer: game-flow controller for one song of the 4-key rhythm game.
// It sequences start, countdown, chart playback, pause/resume, drain and finish.
// It also generates the fall-step tick and reads chart ROM rows for the tracks.
//
// Ports:
//   clk, rst       system clock; asynchronous active-low reset
//   start          pulse; begins a song (accepted in IDLE or DONE)
//   abort          pulse; return to IDLE from any state
//   pause          pulse; toggles pause
//   song_sel       song select, latched on start
//   fall_div       clk cycles per fall step, latched on start
//   row_div        fall steps per chart row, latched on start
//   song_len       chart length in rows, latched on start
//   rom_addr       chart ROM row address
//   rom_data       chart row from the synchronous ROM (1-cycle latency)
//   song_out       latched song_sel; drives the ROM mux
//   fall_tick      one-cycle pulse per fall step
//   row_valid      one-cycle pulse; row_notes is valid
//   row_notes      registered chart row
//   state          current state encoding
//   done           high while in DONE
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start
// COUNTDOWN | COUNT_STEPS fall steps before the first chart row
// PLAY      | chart rows issued every row_div fall steps
// PAUSE     | everything frozen; ret_st remembers where to resume
// DRAIN     | DRAIN_STEPS fall steps so the last notes reach the hit line
// DONE      | song finished; rom_addr holds song_len
module chart_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int COUNT_STEPS = 64,
  parameter int DRAIN_STEPS = 445
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  input  logic [1:0]        song_sel,
  input  logic [15:0]       fall_div,
  input  logic [7:0]        row_div,
  input  logic [ADDR_W-1:0] song_len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [1:0]        song_out,
  output logic              fall_tick,
  output logic              row_valid,
  output logic [3:0]        row_notes,
  output logic [2:0]        state,
  output logic              done
);

  localparam int PW = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_PAUSE     = 3'd3,
    S_DRAIN     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t            st, st_nxt, run_nxt, ret_st, ret_nxt;
  logic [15:0]       tick_cnt, div_lat;
  logic [7:0]        step_cnt, rdiv_lat;
  logic [ADDR_W-1:0] len_lat;
  logic [PW-1:0]     phase_cnt;
  logic              rd_pend;
  logic              start_ok, running, row_evt, last_row, phase_last;

  assign start_ok = start && (st == S_IDLE || st == S_DONE);

  // A zero-length countdown/drain is a single cycle with no tick.
  assign running = (st == S_COUNTDOWN && COUNT_STEPS != 0) || (st == S_PLAY) ||
                   (st == S_DRAIN && DRAIN_STEPS != 0);

  assign fall_tick  = running && (tick_cnt == div_lat - 16'd1);
  assign row_evt    = fall_tick && (st == S_PLAY) && (step_cnt == rdiv_lat - 8'd1);
  assign last_row   = row_evt && (rom_addr == len_lat - ADDR_W'(1));
  assign phase_last = fall_tick && (phase_cnt == PW'(1));

  assign state = st;
  assign done  = (st == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= S_IDLE;
      ret_st <= S_IDLE;
    end else begin
      st     <= st_nxt;
      ret_st <= ret_nxt;
    end
  end

  always_comb begin
    run_nxt = st;
    case (st)
      S_COUNTDOWN: if (COUNT_STEPS == 0 || phase_last) run_nxt = S_PLAY;
      S_PLAY:      if (last_row) run_nxt = S_DRAIN;
      S_DRAIN:     if (DRAIN_STEPS == 0 || phase_last) run_nxt = S_DONE;
      default:     ;
    endcase

    st_nxt  = run_nxt;
    ret_nxt = ret_st;
    if (abort) begin
      st_nxt = S_IDLE;
    end else if (start_ok) begin
      st_nxt = (song_len == '0) ? S_DONE : S_COUNTDOWN;
    end else if (pause) begin
      if (st == S_PAUSE) begin
        st_nxt = ret_st;
      end else if ((st == S_COUNTDOWN || st == S_PLAY || st == S_DRAIN) &&
                   run_nxt != S_DONE) begin
        // Resume into whatever this cycle's tick would have moved us to.
        st_nxt  = S_PAUSE;
        ret_nxt = run_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt  <= '0;
      step_cnt  <= '0;
      rom_addr  <= '0;
      phase_cnt <= '0;
      div_lat   <= 16'd1;
      rdiv_lat  <= 8'd1;
      len_lat   <= '0;
      song_out  <= '0;
    end else if (abort) begin
      tick_cnt  <= '0;
      step_cnt  <= '0;
      rom_addr  <= '0;
      phase_cnt <= '0;
    end else if (start_ok) begin
      song_out  <= song_sel;
      div_lat   <= (fall_div == '0) ? 16'd1 : fall_div;
      rdiv_lat  <= (row_div == '0) ? 8'd1 : row_div;
      len_lat   <= song_len;
      tick_cnt  <= '0;
      step_cnt  <= '0;
      rom_addr  <= '0;
      phase_cnt <= PW'(COUNT_STEPS);
    end else begin
      if (running)
        tick_cnt <= fall_tick ? 16'd0 : tick_cnt + 16'd1;
      if (st == S_PLAY && fall_tick)
        step_cnt <= (step_cnt == rdiv_lat - 8'd1) ? 8'd0 : step_cnt + 8'd1;
      if (row_evt)
        rom_addr <= rom_addr + ADDR_W'(1);
      if (last_row)
        phase_cnt <= PW'(DRAIN_STEPS);
      else if ((st == S_COUNTDOWN || st == S_DRAIN) && fall_tick && phase_cnt != '0)
        phase_cnt <= phase_cnt - PW'(1);
    end
  end

  // ROM read pipeline keeps running through PAUSE; only abort cancels it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend   <= 1'b0;
      row_valid <= 1'b0;
      row_notes <= '0;
    end else if (abort) begin
      rd_pend   <= 1'b0;
      row_valid <= 1'b0;
    end else begin
      rd_pend   <= row_evt;
      row_valid <= rd_pend;
      if (rd_pend)
        row_notes <= rom_data;
    end
  end

endmodule

// File: tb/tb_chart_sequencer.sv
module tb_chart_sequencer;
  localparam int AW = 16;
  localparam int CS = 2;
  localparam int DS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, abort = 1'b0, pause = 1'b0;
  logic [1:0]    song_sel = 2'd0;
  logic [15:0]   fall_div = 16'd3;
  logic [7:0]    row_div = 8'd2;
  logic [AW-1:0] song_len = 16'd3;
  logic [AW-1:0] rom_addr;
  logic [3:0]    rom_data = 4'd0;
  logic [1:0]    song_out;
  logic          fall_tick, row_valid;
  logic [3:0]    row_notes;
  logic [2:0]    state;
  logic          done;

  logic [3:0] rom [4][64];

  chart_sequencer #(.ADDR_W(AW), .COUNT_STEPS(CS), .DRAIN_STEPS(DS)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
    .song_sel(song_sel), .fall_div(fall_div), .row_div(row_div), .song_len(song_len),
    .rom_addr(rom_addr), .rom_data(rom_data), .song_out(song_out),
    .fall_tick(fall_tick), .row_valid(row_valid), .row_notes(row_notes),
    .state(state), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[song_out][rom_addr[5:0]];

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { longint due; int data; } pend_t;
  pend_t  q[$];
  longint cyc = 0;
  int m_st, m_ret, m_pos, m_D, m_R, m_len, m_song, m_ph, m_step, m_row, m_notes;
  bit m_rv;

  function automatic bit is_run(input int s);
    return (s == 1 && CS != 0) || s == 2 || (s == 4 && DS != 0);
  endfunction

  task automatic model_reset();
    m_st = 0; m_ret = 0; m_pos = 0; m_D = 1; m_R = 1; m_len = 0; m_song = 0;
    m_ph = 0; m_step = 0; m_row = 0; m_notes = 0; m_rv = 0;
    q.delete();
  endtask

  task automatic model_step();
    int nst;
    bit tk;
    pend_t p;
    if (abort) begin
      q.delete();
      m_st = 0; m_pos = 0; m_step = 0; m_row = 0; m_ph = 0;
    end else if (start && (m_st == 0 || m_st == 5)) begin
      m_song = int'(song_sel);
      m_D    = (fall_div == 0) ? 1 : int'(fall_div);
      m_R    = (row_div == 0) ? 1 : int'(row_div);
      m_len  = int'(song_len);
      m_pos = 0; m_step = 0; m_row = 0; m_ph = 0;
      m_st = (song_len == 0) ? 5 : 1;
    end else begin
      nst = m_st;
      tk  = is_run(m_st) && (m_pos == m_D - 1);
      if (is_run(m_st)) m_pos = (m_pos + 1) % m_D;
      if (m_st == 1) begin
        if (tk) m_ph++;
        if (CS == 0 || m_ph == CS) begin nst = 2; m_ph = 0; m_step = 0; end
      end else if (m_st == 2 && tk) begin
        if (m_step == m_R - 1) begin
          p.due = cyc + 2;
          p.data = int'(rom[m_song][m_row % 64]);
          q.push_back(p);
          if (m_row == m_len - 1) begin nst = 4; m_ph = 0; end
          m_row = (m_row + 1) % 65536;
          m_step = 0;
        end else begin
          m_step++;
        end
      end else if (m_st == 4) begin
        if (tk) m_ph++;
        if (DS == 0 || m_ph == DS) nst = 5;
      end
      if (pause) begin
        if (m_st == 3) nst = m_ret;
        else if ((m_st == 1 || m_st == 2 || m_st == 4) && nst != 5) begin
          m_ret = nst;
          nst = 3;
        end
      end
      m_st = nst;
    end
    cyc++;
    m_rv = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      m_rv = 1;
      m_notes = q[0].data;
      void'(q.pop_front());
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  // Continuous comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("state", state, m_st);
      chk("done", done, m_st == 5);
      chk("rom_addr", rom_addr, m_row);
      chk("song_out", song_out, m_song);
      chk("fall_tick", fall_tick, is_run(m_st) && (m_pos == m_D - 1));
      chk("row_valid", row_valid, m_rv);
      chk("row_notes", row_notes, m_notes);
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0; pause = 1'b0;
  endtask

  task automatic set_cfg(input int s, input int fd, input int rd, input int len);
    song_sel = 2'(s); fall_div = 16'(fd); row_div = 8'(rd); song_len = 16'(len);
  endtask

  task automatic go_idle();
    next_cycle();
    abort = 1'b1;
    next_cycle();
    set_cfg(2, 3, 2, 3);
  endtask

  initial begin
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 64; a++)
        rom[s][a] = 4'($urandom_range(0, 15));
    rom[2][0] = 4'b0001;
    rom[2][1] = 4'b1010;
    rom[2][2] = 4'b1111;

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Nominal song: schedule, ROM rows and latching.
    go_idle();
    start = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) next_cycle();
      if (c == 1) set_cfg(1, 7, 5, 9);
      @(negedge clk);
      chk("t1_tick", fall_tick, c >= 3 && c <= 36 && c % 3 == 0);
      chk("t1_state", state, c == 0 ? 0 : c <= 6 ? 1 : c <= 24 ? 2 : c <= 36 ? 4 : 5);
      chk("t1_rv", row_valid, c == 14 || c == 20 || c == 26);
      chk("t1_addr", rom_addr, c < 13 ? 0 : c < 19 ? 1 : c < 25 ? 2 : 3);
      chk("t1_done", done, c >= 37);
      if (c >= 1) chk("t1_song", song_out, 2);
      if (c == 14) chk("t2_row0", row_notes, 4'b0001);
      if (c == 20) chk("t2_row1", row_notes, 4'b1010);
      if (c == 26) chk("t2_row2", row_notes, 4'b1111);
    end

    // Pause at 10, resume at 20.
    go_idle();
    start = 1'b1;
    for (int c = 0; c <= 45; c++) begin
      if (c > 0) next_cycle();
      if (c == 10 || c == 20) pause = 1'b1;
      @(negedge clk);
      chk("t3_tick", fall_tick,
          (c >= 3 && c <= 9 && c % 3 == 0) || (c >= 22 && (c - 22) % 3 == 0));
      if (c >= 11 && c <= 20) chk("t3_paused", state, 3);
      if (c == 10 || c == 21) chk("t3_play", state, 2);
      if (c == 14 || c == 24) chk("t3_rv", row_valid, c == 24);
    end

    // Abort right after a row event, then replay.
    go_idle();
    start = 1'b1;
    for (int c = 0; c <= 41; c++) begin
      if (c > 0) next_cycle();
      if (c == 13) abort = 1'b1;
      if (c == 20) begin set_cfg(2, 3, 2, 3); start = 1'b1; end
      @(negedge clk);
      if (c == 13) chk("t4_addr_pre", rom_addr, 1);
      if (c == 14) begin
        chk("t4_idle", state, 0);
        chk("t4_rv_supp", row_valid, 0);
        chk("t4_addr_clr", rom_addr, 0);
      end
      if (c == 33) chk("t4_addr_re", rom_addr, 1);
      if (c == 34) begin chk("t4_rv_re", row_valid, 1); chk("t4_row0", row_notes, 4'b0001); end
      if (c == 40) begin chk("t4_rv_re1", row_valid, 1); chk("t4_row1", row_notes, 4'b1010); end
    end

    // Zero-length song, then divider 0 from DONE.
    go_idle();
    set_cfg(1, 3, 2, 0);
    start = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) next_cycle();
      if (c == 3) begin set_cfg(1, 0, 0, 5); start = 1'b1; end
      @(negedge clk);
      if (c == 1 || c == 2) begin
        chk("t5_done_st", state, 5);
        chk("t5_done", done, 1);
        chk("t5_notick", fall_tick, 0);
      end
      if (c >= 4) begin
        chk("t5_tick", fall_tick, (c - 3) <= 11);
        chk("t5_rv", row_valid, (c - 3) >= 5 && (c - 3) <= 9);
      end
      if (c == 6) chk("t5_play", state, 2);
      if (c == 8) chk("t5_row0", row_notes, rom[1][0]);
      if (c == 15) begin chk("t5_end", state, 5); chk("t5_addr", rom_addr, 5); end
    end

    // Ignored start, start+abort in DONE, async reset mid-PLAY.
    go_idle();
    set_cfg(0, 3, 2, 3);
    start = 1'b1;
    for (int c = 0; c <= 50; c++) begin
      if (c > 0) next_cycle();
      if (c == 8) begin set_cfg(3, 5, 1, 1); start = 1'b1; end
      if (c == 38) begin start = 1'b1; abort = 1'b1; end
      if (c == 40) begin set_cfg(0, 3, 2, 3); start = 1'b1; end
      @(negedge clk);
      if (c == 9) begin
        chk("t6_ign_st", state, 2);
        chk("t6_ign_song", song_out, 0);
        chk("t6_ign_tick", fall_tick, 1);
      end
      if (c == 12) chk("t6_ign_tick2", fall_tick, 1);
      if (c == 37) chk("t6_done", state, 5);
      if (c == 39) begin chk("t6_abort_st", state, 0); chk("t6_abort_song", song_out, 0); end
      if (c == 50) chk("t6_play", state, 2);
    end
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_state", state, 0);
    chk("t6_rst_addr", rom_addr, 0);
    chk("t6_rst_tick", fall_tick, 0);
    chk("t6_rst_rv", row_valid, 0);
    chk("t6_rst_notes", row_notes, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_song", song_out, 0);
    next_cycle();
    next_cycle();
    rst = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      next_cycle();
      set_cfg($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
              $urandom_range(0, 6));
      start = ($urandom_range(0, 99) < 6);
      abort = ($urandom_range(0, 199) == 0);
      pause = ($urandom_range(0, 99) < 3);
    end
    next_cycle();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/chart_sequencer.md
Name: chart_sequencer

Overview:
Top-level game-flow controller for the 4-key rhythm game. It sequences one song: start, countdown, chart playback, pause/resume, drain and finish. It generates the fall-step tick that shifts the falling note tracks, and reads the per-song chart ROM rows that feed the track inputs. It sits between the user controls (start, pause, song switches) and the track/scoring datapath.

Parameters:
ADDR_W, 16, chart ROM address width
COUNT_STEPS, 64, fall steps spent in COUNTDOWN before the first chart row
DRAIN_STEPS, 445, fall steps after the last row so the final notes reach the hit line

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; begins a song
abort  in  1  one-cycle pulse; returns to IDLE
pause  in  1  one-cycle pulse; toggles pause
song_sel  in  2  song select, latched on start
fall_div  in  16  clk cycles per fall step, latched on start
row_div  in  8  fall steps per chart row, latched on start
song_len  in  ADDR_W  chart length in rows, latched on start
rom_addr  out  ADDR_W  chart ROM row address
rom_data  in  4  chart row, one bit per key; synchronous ROM, 1-cycle latency
song_out  out  2  latched song_sel; drives the ROM mux
fall_tick  out  1  one-cycle pulse per fall step
row_valid  out  1  one-cycle pulse; row_notes is valid
row_notes  out  4  registered chart row
state  out  3  IDLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, DRAIN=4, DONE=5
done  out  1  high while in DONE

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all counters 0; rom_addr=0; song_out=0.
  - fall_tick=0, row_valid=0, row_notes=0, done=0.
- start, accepted only in IDLE or DONE:
  - latch song_sel, fall_div, row_div and song_len.
  - clear the tick, step and row counters; clear rom_addr.
  - next state is COUNTDOWN, or DONE directly if song_len==0.
- Tick counter:
  - runs only in COUNTDOWN, PLAY and DRAIN; holds its value in PAUSE.
  - counts 0..D-1, where D=max(fall_div,1); fall_tick=1 in the cycle the count equals D-1.
  - not reset on COUNTDOWN->PLAY or PLAY->DRAIN, so tick spacing stays uniform.
  - fall_div=1 or 0 gives a tick every cycle.
- COUNTDOWN: after COUNT_STEPS ticks, go to PLAY in the cycle following the last tick. COUNT_STEPS=0 means COUNTDOWN lasts 1 cycle with no tick.
- PLAY:
  - step counter cleared on entry; incremented on each tick; wraps at R=max(row_div,1).
  - Row event = tick while step==R-1.
  - On a row event at cycle T, the ROM samples rom_addr at the end of T and rom_addr increments at the end of T.
  - rom_data is captured into row_notes at the end of T+1; row_valid=1 in cycle T+2 only.
  - Row index wraps modulo 2^ADDR_W; this cannot occur while song_len is in range.
  - When the row event issues row song_len-1, next state is DRAIN.
- DRAIN: after DRAIN_STEPS ticks, go to DONE. DRAIN_STEPS=0 means 1 cycle.
- DONE: no ticks; done=1; rom_addr holds song_len.
- pause:
  - In COUNTDOWN, PLAY or DRAIN: enter PAUSE next cycle and remember the return state.
  - In PAUSE: resume the saved state with all counters intact.
  - Ignored in IDLE and DONE.
  - A fall_tick or row event in the same cycle as pause still takes effect.
  - An in-flight ROM read completes and pulses row_valid even while in PAUSE.
- abort: from any state go to IDLE next cycle and clear counters and rom_addr; a pending row_valid is suppressed.
- Priority within one cycle: abort > start > pause. start in a non-IDLE/DONE state is ignored.
- Config inputs may change freely; only the latched copies are used.

Test Plan:
1. COUNT_STEPS=2, DRAIN_STEPS=4, fall_div=3, row_div=2, song_len=3, start at cycle 0 -> fall_tick at cycles 3,6,9,...,36; PLAY from cycle 7; row events at 12,18,24; row_valid at 14,20,26; rom_addr 0->1->2->3 at 13,19,25; DRAIN from 25; DONE and done=1 from 37.
2. ROM rows 4'b0001, 4'b1010, 4'b1111 with the setup of test 1 -> row_notes equals each in turn when row_valid is high, with song_out held at the song_sel sampled at start.
3. Pause pulse at cycle 10, resume pulse at cycle 20 (test 1 setup) -> state=3 during 11..20; no fall_tick in 11..20; the next fall_tick at cycle 22 keeps the tick phase, so the schedule shifts by 10 cycles.
4. abort at cycle 13, right after a row event -> IDLE at 14; no row_valid at 14; rom_addr=0; a new start at 20 replays the schedule from row 0.
5. song_len=0 with start -> DONE the next cycle, no fall_tick. fall_div=0 with row_div=0 -> a tick every cycle and a row event every tick.
6. start asserted during PLAY -> ignored. start and abort in the same cycle while in DONE -> IDLE. rst pulled low mid-PLAY -> outputs at reset values immediately, without waiting for a clock edge.
